// File: rtl/apb_pkg.sv
// Shared FSM encoding and address-decode constants for the APB host port.
package apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACC,
        RD_ACC,
        RD_DATA,
        ERR_ACC
    } apb_state_e;

    // Byte-offset bits below the register index (word access only).
    localparam int unsigned BYTE_OFS_W = 2;

    localparam int unsigned TX_STATUS = 2;
    localparam int unsigned RX_STATUS = 6;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB byte address -> register index / illegal flag.
// Illegal-address detection is built only when APB_SLVERR_EN is defined.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int PADDR_WIDTH = 12
) (
    input  logic [PADDR_WIDTH-1:0] paddr_i,
    output logic [ADDR_WIDTH-1:0]  index_o,
    output logic                   illegal_o
);

    assign index_o = paddr_i[ADDR_WIDTH+BYTE_OFS_W-1:BYTE_OFS_W];

`ifdef APB_SLVERR_EN
    assign illegal_o = (paddr_i[BYTE_OFS_W-1:0] != '0) ||
                       (paddr_i[PADDR_WIDTH-1:ADDR_WIDTH+BYTE_OFS_W] != '0);
`else
    // Offset and upper bits are don't-care: addresses alias onto the register window.
    logic unused_paddr;
    assign unused_paddr = ^{paddr_i[PADDR_WIDTH-1:ADDR_WIDTH+BYTE_OFS_W],
                            paddr_i[BYTE_OFS_W-1:0]};
    assign illegal_o    = 1'b0;
`endif

endmodule

// File: rtl/apb_host_if.sv
// APB3 slave front-end for the CAN/LIN register file host port.
// Define APB_SLVERR_EN to return PSLVERR on misaligned / out-of-window addresses.
module apb_host_if
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int PADDR_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PADDR_WIDTH-1:0] paddr,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [DATA_WIDTH-1:0]  pwdata,
    output logic [DATA_WIDTH-1:0]  prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [ADDR_WIDTH-1:0]  rf_addr,
    output logic [DATA_WIDTH-1:0]  rf_wdata,
    output logic                   rf_we,
    output logic                   rf_re,
    input  logic [DATA_WIDTH-1:0]  rf_rdata,
    input  logic                   txreq,
    input  logic                   msgrec,
    output logic                   irq
);

    apb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  rf_addr_q;
    logic [DATA_WIDTH-1:0]  rf_wdata_q;
    logic                   irq_q;
    logic [ADDR_WIDTH-1:0]  dec_index;
    logic                   dec_illegal;
    logic                   capture;

    apb_addr_decode #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .PADDR_WIDTH (PADDR_WIDTH)
    ) u_decode (
        .paddr_i   (paddr),
        .index_o   (dec_index),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= txreq | msgrec;
            if (capture) begin
                rf_addr_q  <= dec_index;
                rf_wdata_q <= pwdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    capture = 1'b1;
                    if (dec_illegal)  state_d = ERR_ACC;
                    else if (pwrite)  state_d = WR_ACC;
                    else              state_d = RD_ACC;
                end
            end
            WR_ACC:  state_d = IDLE;
            // A host dropping PSEL mid-read abandons the transfer without PREADY.
            RD_ACC:  state_d = psel ? RD_DATA : IDLE;
            RD_DATA: state_d = IDLE;
            ERR_ACC: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and handshake decode straight from state so reset clears them at once.
    always_comb begin
        rf_we   = (state_q == WR_ACC);
        rf_re   = (state_q == RD_ACC) && psel;
        pready  = (state_q == WR_ACC) || (state_q == ERR_ACC) ||
                  ((state_q == RD_DATA) && psel);
        prdata  = ((state_q == RD_DATA) && psel) ? rf_rdata : '0;
`ifdef APB_SLVERR_EN
        pslverr = (state_q == ERR_ACC);
`else
        pslverr = 1'b0;
`endif
    end

    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_apb_host_if.sv
// Directed self-checking bench for apb_host_if (inputs driven and outputs sampled on falling edges).
module tb_apb_host_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata, rf_wdata, rf_rdata;
    logic        pready, pslverr, rf_we, rf_re, txreq, msgrec, irq;
    logic [2:0]  rf_addr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_host_if dut (
        .clk      (clk),
        .reset    (reset),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .rf_we    (rf_we),
        .rf_re    (rf_re),
        .rf_rdata (rf_rdata),
        .txreq    (txreq),
        .msgrec   (msgrec),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prdata"},  prdata,   32'h0);
        check({tag, "_pready"},  {31'b0, pready},  32'h0);
        check({tag, "_pslverr"}, {31'b0, pslverr}, 32'h0);
        check({tag, "_rf_addr"}, {29'b0, rf_addr}, 32'h0);
        check({tag, "_rf_wdata"}, rf_wdata, 32'h0);
        check({tag, "_rf_we"},   {31'b0, rf_we},   32'h0);
        check({tag, "_rf_re"},   {31'b0, rf_re},   32'h0);
        check({tag, "_irq"},     {31'b0, irq},     32'h0);
    endtask

    task automatic setup(input logic [11:0] a, input logic wr, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d;
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0;
    endtask

    // Starts at a falling edge in IDLE, ends at the falling edge of the following IDLE cycle.
    task automatic do_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                            input logic [2:0] exp_idx);
        setup(a, 1'b1, d);
        @(posedge clk); @(negedge clk);
        check({tag, "_we"},     {31'b0, rf_we},   32'h1);
        check({tag, "_re"},     {31'b0, rf_re},   32'h0);
        check({tag, "_pready"}, {31'b0, pready},  32'h1);
        check({tag, "_slverr"}, {31'b0, pslverr}, 32'h0);
        check({tag, "_addr"},   {29'b0, rf_addr}, {29'b0, exp_idx});
        check({tag, "_wdata"},  rf_wdata, d);
        penable = 1'b1;
        @(posedge clk); @(negedge clk);
        check({tag, "_we_done"}, {31'b0, rf_we}, 32'h0);
    endtask

    task automatic do_read(input string tag, input logic [11:0] a, input logic [31:0] rd,
                           input logic [2:0] exp_idx);
        setup(a, 1'b0, 32'h0);
        rf_rdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        check({tag, "_re_t1"},     {31'b0, rf_re},   32'h1);
        check({tag, "_we_t1"},     {31'b0, rf_we},   32'h0);
        check({tag, "_pready_t1"}, {31'b0, pready},  32'h0);
        check({tag, "_prdata_t1"}, prdata,           32'h0);
        check({tag, "_addr"},      {29'b0, rf_addr}, {29'b0, exp_idx});
        penable  = 1'b1;
        rf_rdata = rd;
        @(posedge clk); @(negedge clk);
        check({tag, "_re_t2"},     {31'b0, rf_re},   32'h0);
        check({tag, "_pready_t2"}, {31'b0, pready},  32'h1);
        check({tag, "_slverr_t2"}, {31'b0, pslverr}, 32'h0);
        check({tag, "_prdata_t2"}, prdata,           rd);
        @(posedge clk); @(negedge clk);
        check({tag, "_pready_done"}, {31'b0, pready}, 32'h0);
        check({tag, "_prdata_done"}, prdata,          32'h0);
    endtask

`ifdef APB_SLVERR_EN
    task automatic do_err(input string tag, input logic [11:0] a, input logic wr);
        setup(a, wr, 32'h1234_5678);
        rf_rdata = 32'hFFFF_FFFF;
        @(posedge clk); @(negedge clk);
        check({tag, "_pready"}, {31'b0, pready},  32'h1);
        check({tag, "_slverr"}, {31'b0, pslverr}, 32'h1);
        check({tag, "_we"},     {31'b0, rf_we},   32'h0);
        check({tag, "_re"},     {31'b0, rf_re},   32'h0);
        check({tag, "_prdata"}, prdata,           32'h0);
        penable = 1'b1;
        @(posedge clk); @(negedge clk);
        check({tag, "_slverr_done"}, {31'b0, pslverr}, 32'h0);
    endtask
`endif

    initial begin
        reset = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = '0; rf_rdata = '0; txreq = 1'b0; msgrec = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_write("wr08", 12'h008, 32'hA5A5_0001, 3'd2);
        idle(); @(negedge clk);

        do_read("rd18", 12'h018, 32'h0000_0001, 3'd6);
        idle(); @(negedge clk);

        // Back-to-back: read setup lands in the IDLE cycle right after the write completes.
        do_write("b2b_wr", 12'h004, 32'h0BAD_F00D, 3'd1);
        do_read("b2b_rd", 12'h004, 32'h0BAD_F00D, 3'd1);
        idle(); @(negedge clk);

`ifdef APB_SLVERR_EN
        do_err("err022", 12'h022, 1'b1);
        idle(); @(negedge clk);
        do_err("err100", 12'h100, 1'b0);
        idle(); @(negedge clk);
`else
        do_read("alias100", 12'h100, 32'h5555_AAAA, 3'd0);
        idle(); @(negedge clk);
        do_write("alias022", 12'h022, 32'h0000_0022, 3'd0);
        idle(); @(negedge clk);
`endif

        // Asynchronous reset in the middle of a read wait state.
        txreq = 1'b1;
        setup(12'h01C, 1'b0, 32'h0);
        @(posedge clk); @(negedge clk);
        check("rst_pre_re",  {31'b0, rf_re}, 32'h1);
        check("rst_pre_irq", {31'b0, irq},   32'h1);
        #1 reset = 1'b0;
        #1 check_all_zero("rst_mid");
        idle(); txreq = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_write("post_rst", 12'h00C, 32'hCAFE_0003, 3'd3);
        idle(); @(negedge clk);

        // Interrupt follows txreq|msgrec with one cycle of lag.
        msgrec = 1'b1;
        #1 check("irq_lag_rise", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("irq_rise", {31'b0, irq}, 32'h1);
        msgrec = 1'b0;
        #1 check("irq_lag_fall", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("irq_fall", {31'b0, irq}, 32'h0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_host_if.md
# apb_host_if

APB3 slave front-end for the CAN/LIN register file's host port (port 1). It converts APB setup/access phases into single-cycle write/read strobes on the register file and inserts the wait state its registered read data requires. It also flags illegal addresses and forwards the register file's transmit-done and message-received flags to the host as one interrupt line.

## Interface
- DATA_WIDTH, 32: APB and register data width.
- ADDR_WIDTH, 3: register index width (8 registers).
- PADDR_WIDTH, 12: APB byte-address width.
---
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- paddr  in  PADDR_WIDTH  APB byte address.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_WIDTH  APB write data.
- prdata  out  DATA_WIDTH  APB read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- rf_addr  out  ADDR_WIDTH  register index to register file.
- rf_wdata  out  DATA_WIDTH  write data to register file.
- rf_we  out  1  one-cycle write strobe.
- rf_re  out  1  one-cycle read strobe.
- rf_rdata  in  DATA_WIDTH  register-file read data, valid the cycle after rf_re.
- txreq  in  1  transmit-done flag from register file.
- msgrec  in  1  message-received flag from register file.
- irq  out  1  registered txreq | msgrec.

## Operation
- Register index = paddr[ADDR_WIDTH+1:2]. Word access only.
- FSM states are IDLE, WR_ACC, RD_ACC, RD_DATA and ERR_ACC.
- IDLE:
  - psel & ~penable (setup phase) captures the index into rf_addr and pwdata into rf_wdata.
  - Then goes to ERR_ACC if the address is illegal, otherwise WR_ACC if pwrite=1, otherwise RD_ACC.
- WR_ACC:
  - rf_we=1 and pready=1.
  - Goes to IDLE.
- RD_ACC:
  - rf_re=1 and pready=0.
  - Goes to RD_DATA.
- RD_DATA:
  - pready=1 and prdata=rf_rdata.
  - Goes to IDLE.
- ERR_ACC:
  - pready=1 and pslverr=1, with no strobe.
  - Goes to IDLE.
- prdata is 0 in every state except RD_DATA.
- rf_we and rf_re are never high together. Each is high for exactly one cycle per legal transfer.
- psel=0 in RD_ACC or RD_DATA aborts the transfer to IDLE with no pready (protocol violation tolerated).
- irq is updated every cycle from txreq | msgrec. The host clears the source by writing the register file.

## Timing
- Reset values:
  - State is IDLE.
  - prdata=0, pready=0, pslverr=0, rf_addr=0, rf_wdata=0, rf_we=0, rf_re=0, irq=0.
- Reset assertion forces these values immediately, including mid-transfer. Any pending strobe is dropped.
- Write:
  - Setup in cycle T0; rf_we and pready in T1.
  - Zero wait states; the register file captures at the end of T1.
- Read:
  - Setup T0; rf_re in T1; pready and prdata in T2.
  - One wait state.
- Error: pready and pslverr in T1; zero wait states.
- Back-to-back: the FSM is in IDLE in the cycle after completion, so a setup phase in that cycle is accepted with no dead cycle.
- irq lags txreq/msgrec by one cycle.

## Configuration
- APB_SLVERR_EN defined:
  - An address is illegal if paddr[1:0]≠0 or paddr[PADDR_WIDTH-1:ADDR_WIDTH+2]≠0.
  - Illegal addresses take the ERR_ACC path.
- APB_SLVERR_EN undefined:
  - Upper and low address bits are ignored, so addresses alias onto the 8 registers.
  - ERR_ACC is unreachable and pslverr is tied 0.

## Structure
- Package apb_pkg holds:
  - The FSM state encoding.
  - APB address-decode constants.
  - Register index constants: TX_STATUS=2, RX_STATUS=6.
- One sub-module, apb_addr_decode: combinational paddr → {index, illegal}, with the illegal term guarded by APB_SLVERR_EN.

## Test plan
- Write paddr=0x008, pwdata=0xA5A5_0001 → rf_we pulses in T1 with rf_addr=2 and rf_wdata=0xA5A5_0001; pready=1 in T1.
- Read paddr=0x018 with rf_rdata=0x0000_0001 in T2 → rf_re in T1 only; pready=1 and prdata=0x0000_0001 in T2.
- Back-to-back write to 0x004 then read of 0x004 → no idle cycle between them; read completes 2 cycles after its setup phase.
- With APB_SLVERR_EN, write to 0x022 and read of 0x100 → pready=pslverr=1 in T1, no rf_we/rf_re, prdata=0. Without the macro, 0x100 reads register 0.
- Assert reset during RD_ACC → all outputs 0 at once; the first post-reset transfer completes normally.
- msgrec 0→1 → irq=1 one cycle later; msgrec 1→0 → irq=0 one cycle later.
